// File: rtl/gamma_lut_ctrl.sv
// gamma_lut_ctrl: fills and double-buffers the gamma lookup RAM and swaps banks on frame boundaries
module gamma_lut_ctrl #(
  parameter int LUT_AW = 7,
  parameter int LUT_DW = 8
) (
  input  logic              VCLK,
  input  logic              nRST,
  input  logic              host_wr_en_i,
  input  logic [LUT_AW-1:0] host_addr_i,
  input  logic [LUT_DW-1:0] host_data_i,
  input  logic              host_commit_i,
  input  logic              host_fill_i,
  output logic              host_ready_o,
  output logic              commit_done_o,
  output logic              init_done_o,
  input  logic              nVSYNC_i,
  input  logic              vdata_valid_i,
  output logic              lut_we_o,
  output logic [LUT_AW:0]   lut_waddr_o,
  output logic [LUT_DW-1:0] lut_wdata_o,
  output logic              rd_bank_o
);
  typedef enum logic [1:0] {INIT, IDLE, FILL, ARMED} state_t;
  state_t state_q, state_d;
  logic [LUT_AW:0] cnt_q, cnt_d, waddr_q, waddr_d;
  logic [LUT_DW-1:0] wdata_q, wdata_d;
  logic we_q, we_d, bank_q, bank_d, done_q, done_d, init_q, init_d;
  logic pend_q, pend_d, ready_q, vs_q, vsync_fall;
  function automatic logic [LUT_DW-1:0] ramp(input logic [LUT_AW-1:0] a);
    logic [LUT_AW+LUT_DW-1:0] t;
    t = {a, {LUT_DW{1'b0}}};
    t = t | (t >> LUT_AW);
    return t[LUT_AW+LUT_DW-1 -: LUT_DW];
  endfunction
  assign vsync_fall = vs_q & ~nVSYNC_i;
  // Next state and next output values; INIT ends once the wrapped counter follows a write
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    bank_d  = bank_q;
    done_d  = 1'b0;
    init_d  = init_q;
    pend_d  = pend_q;
    case (state_q)
      INIT:
        if (we_q && cnt_q == '0) begin
          state_d = IDLE;
          init_d  = 1'b1;
        end else begin
          we_d    = 1'b1;
          waddr_d = cnt_q;
          wdata_d = ramp(cnt_q[LUT_AW-1:0]);
          cnt_d   = cnt_q + 1'b1;
        end
      IDLE: begin
        if (host_wr_en_i) begin
          we_d    = 1'b1;
          waddr_d = {~bank_q, host_addr_i};
          wdata_d = host_data_i;
        end
        if (host_fill_i) begin
          state_d = FILL;
          cnt_d   = '0;
        end else if (host_commit_i) begin
          state_d = ARMED;
          pend_d  = 1'b0;
        end
      end
      FILL:
        if (cnt_q[LUT_AW]) begin
          state_d = IDLE;
        end else begin
          we_d    = 1'b1;
          waddr_d = {~bank_q, cnt_q[LUT_AW-1:0]};
          wdata_d = ramp(cnt_q[LUT_AW-1:0]);
          cnt_d   = cnt_q + 1'b1;
        end
      ARMED:
        if (vdata_valid_i && pend_q) begin
          bank_d  = ~bank_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          pend_d = pend_q | vsync_fall;
        end
      default: state_d = INIT;
    endcase
  end
  // State and registered outputs; reset restarts INIT from address 0 on bank 0
  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= INIT;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      bank_q  <= 1'b0;
      done_q  <= 1'b0;
      init_q  <= 1'b0;
      pend_q  <= 1'b0;
      ready_q <= 1'b0;
      vs_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      bank_q  <= bank_d;
      done_q  <= done_d;
      init_q  <= init_d;
      pend_q  <= pend_d;
      ready_q <= (state_d == IDLE);
      vs_q    <= nVSYNC_i;
    end
  end
  assign host_ready_o  = ready_q;
  assign commit_done_o = done_q;
  assign init_done_o   = init_q;
  assign lut_we_o      = we_q;
  assign lut_waddr_o   = waddr_q;
  assign lut_wdata_o   = wdata_q;
  assign rd_bank_o     = bank_q;
endmodule

// File: tb/tb_gamma_lut_ctrl.sv
// tb_gamma_lut_ctrl: randomized scenario bench for gamma_lut_ctrl against a RAM/bank reference model
module tb_gamma_lut_ctrl;
  logic VCLK = 1'b0;
  logic nRST, host_wr_en_i, host_commit_i, host_fill_i, nVSYNC_i, vdata_valid_i;
  logic [6:0] host_addr_i;
  logic [7:0] host_data_i, lut_waddr_o, lut_wdata_o;
  logic host_ready_o, commit_done_o, init_done_o, lut_we_o, rd_bank_o;
  int checks = 0;
  int errors = 0;
  logic exp_bank = 1'b0;
  logic [7:0] ref_mem [256];
  logic [7:0] dut_mem [256];
  gamma_lut_ctrl dut (
    .VCLK(VCLK), .nRST(nRST), .host_wr_en_i(host_wr_en_i), .host_addr_i(host_addr_i),
    .host_data_i(host_data_i), .host_commit_i(host_commit_i), .host_fill_i(host_fill_i),
    .host_ready_o(host_ready_o), .commit_done_o(commit_done_o), .init_done_o(init_done_o),
    .nVSYNC_i(nVSYNC_i), .vdata_valid_i(vdata_valid_i), .lut_we_o(lut_we_o),
    .lut_waddr_o(lut_waddr_o), .lut_wdata_o(lut_wdata_o), .rd_bank_o(rd_bank_o)
  );
  always #5 VCLK = ~VCLK;
  always @(negedge VCLK) if (lut_we_o === 1'b1) dut_mem[lut_waddr_o] = lut_wdata_o;
  function automatic logic [7:0] ramp(input int a);
    int b;
    b = a % 128;
    return 8'((b * 2) + (b / 64));
  endfunction
  task automatic step;
    @(posedge VCLK);
    #1;
  endtask
  task automatic run_init;
    for (int i = 0; i < 256; i++) begin
      step;
      checks++;
      if (lut_we_o !== 1'b1 || lut_waddr_o !== 8'(i) || lut_wdata_o !== ramp(i) || host_ready_o !== 1'b0 || init_done_o !== 1'b0) begin
        errors++;
        $display("FAIL init_write[%0d] got we=%b addr=%h data=%h rdy=%b done=%b want we=1 addr=%h data=%h rdy=0 done=0",
                 i, lut_we_o, lut_waddr_o, lut_wdata_o, host_ready_o, init_done_o, 8'(i), ramp(i));
      end
      ref_mem[i] = ramp(i);
    end
    step;
    exp_bank = 1'b0;
    checks++;
    if (lut_we_o !== 1'b0 || host_ready_o !== 1'b1 || init_done_o !== 1'b1 || rd_bank_o !== 1'b0) begin
      errors++;
      $display("FAIL init_end got we=%b rdy=%b done=%b bank=%b want we=0 rdy=1 done=1 bank=0", lut_we_o, host_ready_o, init_done_o, rd_bank_o);
    end
  endtask
  task automatic check_reset_values(input string name);
    checks++;
    if (lut_we_o !== 1'b0 || lut_waddr_o !== 8'h00 || lut_wdata_o !== 8'h00 || rd_bank_o !== 1'b0 ||
        host_ready_o !== 1'b0 || commit_done_o !== 1'b0 || init_done_o !== 1'b0) begin
      errors++;
      $display("FAIL %s got we=%b addr=%h data=%h bank=%b rdy=%b cd=%b id=%b want all zero", name,
               lut_we_o, lut_waddr_o, lut_wdata_o, rd_bank_o, host_ready_o, commit_done_o, init_done_o);
    end
  endtask
  task automatic host_cycle(input logic wr, input logic [6:0] a, input logic [7:0] d);
    host_wr_en_i = wr;
    host_addr_i  = a;
    host_data_i  = d;
    step;
    host_wr_en_i = 1'b0;
    checks++;
    if (wr && (lut_we_o !== 1'b1 || lut_waddr_o !== {~exp_bank, a} || lut_wdata_o !== d || host_ready_o !== 1'b1)) begin
      errors++;
      $display("FAIL host_write got we=%b addr=%h data=%h rdy=%b want we=1 addr=%h data=%h rdy=1",
               lut_we_o, lut_waddr_o, lut_wdata_o, host_ready_o, {~exp_bank, a}, d);
    end
    if (!wr && (lut_we_o !== 1'b0 || host_ready_o !== 1'b1)) begin
      errors++;
      $display("FAIL host_idle got we=%b rdy=%b want we=0 rdy=1", lut_we_o, host_ready_o);
    end
    if (wr) ref_mem[{~exp_bank, a}] = d;
  endtask
  task automatic test_reset;
    nRST = 1'b0;
    repeat (3) step;
    check_reset_values("reset_values");
    nRST = 1'b1;
    run_init;
  endtask
  task automatic test_host_write;
    host_cycle(1'b1, 7'h10, 8'h55);
    for (int i = 0; i < 30; i++) host_cycle(1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom));
  endtask
  task automatic test_commit_fill;
    logic [6:0] a;
    logic [7:0] d;
    a = 7'($urandom);
    d = 8'($urandom);
    host_wr_en_i = 1'b1; host_addr_i = a; host_data_i = d;
    host_fill_i = 1'b1; host_commit_i = 1'b1;
    step;
    checks++;
    if (lut_we_o !== 1'b1 || lut_waddr_o !== {~exp_bank, a} || lut_wdata_o !== d || host_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL fill_entry got we=%b addr=%h data=%h rdy=%b want we=1 addr=%h data=%h rdy=0",
               lut_we_o, lut_waddr_o, lut_wdata_o, host_ready_o, {~exp_bank, a}, d);
    end
    ref_mem[{~exp_bank, a}] = d;
    for (int i = 0; i < 128; i++) begin
      host_wr_en_i  = 1'($urandom_range(0, 1));
      host_commit_i = 1'($urandom_range(0, 1));
      host_fill_i   = 1'($urandom_range(0, 1));
      host_addr_i   = 7'($urandom);
      host_data_i   = 8'($urandom);
      step;
      checks++;
      if (lut_we_o !== 1'b1 || lut_waddr_o !== {~exp_bank, 7'(i)} || lut_wdata_o !== ramp(i) || host_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL fill_write[%0d] got we=%b addr=%h data=%h rdy=%b want we=1 addr=%h data=%h rdy=0",
                 i, lut_we_o, lut_waddr_o, lut_wdata_o, host_ready_o, {~exp_bank, 7'(i)}, ramp(i));
      end
      ref_mem[{~exp_bank, 7'(i)}] = ramp(i);
    end
    host_wr_en_i = 1'b0; host_commit_i = 1'b0; host_fill_i = 1'b0;
    step;
    checks++;
    if (lut_we_o !== 1'b0 || host_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL fill_end got we=%b rdy=%b want we=0 rdy=1", lut_we_o, host_ready_o);
    end
    for (int i = 0; i < 8; i++) begin
      nVSYNC_i = (i % 4) != 1;
      vdata_valid_i = 1'($urandom_range(0, 1));
      step;
      checks++;
      if (rd_bank_o !== exp_bank || commit_done_o !== 1'b0) begin
        errors++;
        $display("FAIL fill_no_swap got bank=%b cd=%b want bank=%b cd=0", rd_bank_o, commit_done_o, exp_bank);
      end
    end
    nVSYNC_i = 1'b1; vdata_valid_i = 1'b0;
  endtask
  task automatic test_commit;
    int n;
    host_commit_i = 1'b1;
    step;
    host_commit_i = 1'b0;
    checks++;
    if (host_ready_o !== 1'b0 || rd_bank_o !== exp_bank) begin
      errors++;
      $display("FAIL commit_accept got rdy=%b bank=%b want rdy=0 bank=%b", host_ready_o, rd_bank_o, exp_bank);
    end
    n = $urandom_range(3, 6);
    for (int i = 0; i < n + 3; i++) begin
      nVSYNC_i = (i != n);
      vdata_valid_i = (i < n) ? 1'($urandom_range(0, 1)) : 1'b0;
      host_wr_en_i = 1'b1; host_addr_i = 7'($urandom);
      step;
      checks++;
      if (rd_bank_o !== exp_bank || commit_done_o !== 1'b0 || lut_we_o !== 1'b0 || host_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL commit_wait[%0d] got bank=%b cd=%b we=%b rdy=%b want bank=%b cd=0 we=0 rdy=0",
                 i, rd_bank_o, commit_done_o, lut_we_o, host_ready_o, exp_bank);
      end
    end
    host_wr_en_i = 1'b0;
    nVSYNC_i = 1'b1;
    vdata_valid_i = 1'b1;
    step;
    vdata_valid_i = 1'b0;
    exp_bank = ~exp_bank;
    checks++;
    if (rd_bank_o !== exp_bank || commit_done_o !== 1'b1 || host_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL commit_swap got bank=%b cd=%b rdy=%b want bank=%b cd=1 rdy=1", rd_bank_o, commit_done_o, host_ready_o, exp_bank);
    end
    step;
    checks++;
    if (rd_bank_o !== exp_bank || commit_done_o !== 1'b0 || host_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL commit_after got bank=%b cd=%b rdy=%b want bank=%b cd=0 rdy=1", rd_bank_o, commit_done_o, host_ready_o, exp_bank);
    end
  endtask
  task automatic test_coincident_edge;
    nVSYNC_i = 1'b1;
    step;
    host_commit_i = 1'b1;
    nVSYNC_i = 1'b0;
    step;
    host_commit_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vdata_valid_i = (i % 2) == 0;
      host_wr_en_i = 1'b1; host_fill_i = 1'b1; host_addr_i = 7'($urandom);
      step;
      checks++;
      if (rd_bank_o !== exp_bank || commit_done_o !== 1'b0 || lut_we_o !== 1'b0) begin
        errors++;
        $display("FAIL coincident_wait[%0d] got bank=%b cd=%b we=%b want bank=%b cd=0 we=0", i, rd_bank_o, commit_done_o, lut_we_o, exp_bank);
      end
    end
    host_wr_en_i = 1'b0; host_fill_i = 1'b0;
    vdata_valid_i = 1'b0;
    nVSYNC_i = 1'b1;
    step;
    nVSYNC_i = 1'b0;
    vdata_valid_i = 1'b1;
    step;
    checks++;
    if (rd_bank_o !== exp_bank || commit_done_o !== 1'b0) begin
      errors++;
      $display("FAIL edge_with_valid got bank=%b cd=%b want bank=%b cd=0", rd_bank_o, commit_done_o, exp_bank);
    end
    vdata_valid_i = 1'b0;
    step;
    vdata_valid_i = 1'b1;
    step;
    vdata_valid_i = 1'b0;
    nVSYNC_i = 1'b1;
    exp_bank = ~exp_bank;
    checks++;
    if (rd_bank_o !== exp_bank || commit_done_o !== 1'b1 || host_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL coincident_swap got bank=%b cd=%b rdy=%b want bank=%b cd=1 rdy=1", rd_bank_o, commit_done_o, host_ready_o, exp_bank);
    end
    step;
  endtask
  task automatic test_ram_contents;
    for (int i = 0; i < 256; i++) begin
      checks++;
      if (dut_mem[i] !== ref_mem[i]) begin
        errors++;
        $display("FAIL ram[%02h] got %h want %h", i, dut_mem[i], ref_mem[i]);
      end
    end
  endtask
  task automatic test_reset_mid_fill;
    checks++;
    if (rd_bank_o !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_bank got %b want 1", rd_bank_o);
    end
    host_fill_i = 1'b1;
    step;
    host_fill_i = 1'b0;
    repeat (40) step;
    checks++;
    if (lut_we_o !== 1'b1 || lut_waddr_o !== 8'd39) begin
      errors++;
      $display("FAIL fill_progress got we=%b addr=%h want we=1 addr=27", lut_we_o, lut_waddr_o);
    end
    nRST = 1'b0;
    #2;
    check_reset_values("mid_fill_reset");
    step;
    step;
    nRST = 1'b1;
    run_init;
  endtask
  initial begin
    nRST = 1'b0; host_wr_en_i = 1'b0; host_addr_i = '0; host_data_i = '0;
    host_commit_i = 1'b0; host_fill_i = 1'b0; nVSYNC_i = 1'b1; vdata_valid_i = 1'b0;
    test_reset;
    test_host_write;
    test_commit_fill;
    test_commit;
    test_host_write;
    test_coincident_edge;
    test_ram_contents;
    test_commit;
    test_reset_mid_fill;
    test_ram_contents;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gamma_lut_ctrl.md
# gamma_lut_ctrl

Controller and configurator for the double-buffered gamma lookup RAM used by the PPU gamma stage. It fills both RAM banks with an identity ramp after reset and forwards host LUT writes into the shadow bank. On host commit, it swaps the active read bank at the next frame boundary, aligned to a pixel-valid strobe so no R/G/B triplet mixes banks. It sits between the host register interface (already VCLK-synchronous) and the gamma table RAM write port and bank select.

## Interface
Parameters:
- LUT_AW, 7, LUT entry address width per bank (equals input colour width)
- LUT_DW, 8, LUT data width (output colour width); LUT_DW >= LUT_AW required

Ports:
- VCLK  in  1  video clock; all logic synchronous to it
- nRST  in  1  reset, asynchronous, active-low
- host_wr_en_i  in  1  host LUT write strobe; accepted only when host_ready_o=1
- host_addr_i  in  LUT_AW  host LUT entry address
- host_data_i  in  LUT_DW  host LUT entry data
- host_commit_i  in  1  single-cycle request to activate the shadow bank
- host_fill_i  in  1  single-cycle request to reload the shadow bank with the identity ramp
- host_ready_o  out  1  controller in IDLE; host writes, commit and fill accepted
- commit_done_o  out  1  one-cycle pulse on the cycle rd_bank_o toggles
- init_done_o  out  1  high once the post-reset fill is complete; stays high until reset
- nVSYNC_i  in  1  active-low vertical sync, sampled from the video sync bits
- vdata_valid_i  in  1  pixel-valid strobe, first of the R/G/B slots
- lut_we_o  out  1  RAM write enable
- lut_waddr_o  out  LUT_AW+1  RAM write address; MSB is bank
- lut_wdata_o  out  LUT_DW  RAM write data
- rd_bank_o  out  1  active read bank for the gamma table

## Operation
- Identity ramp: data(a) = {a, a[LUT_AW-1 -: LUT_DW-LUT_AW]}, using MSB replication. With the defaults, 0x00→0x00, 0x40→0x81, 0x7F→0xFF.
- Shadow bank = ~rd_bank_o.
- FSM states:
  - INIT: writes the ramp to all 2^(LUT_AW+1) addresses in ascending order, 0 to max, covering both banks. On completion, goes to IDLE and sets init_done_o.
  - IDLE: host_ready_o=1.
    - host_wr_en_i writes {shadow, host_addr_i} ← host_data_i.
    - host_fill_i goes to FILL.
    - host_commit_i goes to ARMED.
  - FILL: writes the ramp to the shadow bank, addresses 0 to 2^LUT_AW-1, one per cycle, then returns to IDLE.
  - ARMED: clears frame_pending on entry.
    - A falling edge of nVSYNC_i (registered previous value 1, current 0) sets frame_pending.
    - On the first vdata_valid_i=1 cycle with frame_pending already set, rd_bank_o toggles, commit_done_o pulses, and the FSM returns to IDLE.
- Write counter: a single counter of LUT_AW+1 bits is shared by INIT and FILL. It resets to 0 on state entry.
- Priority and boundary rules:
  - In IDLE, if host_fill_i and host_commit_i arrive in the same cycle, fill wins and the commit is discarded.
  - In IDLE, host_wr_en_i in the same cycle as host_commit_i or host_fill_i: the write is performed, then the state changes.
  - All host inputs are ignored while host_ready_o=0 (INIT, FILL, ARMED). No queuing.
  - A nVSYNC_i edge in the same cycle commit is accepted does not count. A later edge is required.
  - A nVSYNC_i edge and vdata_valid_i in the same cycle: the swap happens on the next vdata_valid_i, not this one.
  - vdata_valid_i without frame_pending has no effect. nVSYNC_i edges outside ARMED have no effect.
- Reset mid-operation: all state is discarded, rd_bank_o returns to 0, and INIT restarts from address 0.

## Timing
- Reset values: lut_we_o=0, lut_waddr_o=0, lut_wdata_o=0, rd_bank_o=0, host_ready_o=0, commit_done_o=0, init_done_o=0. The FSM is in INIT.
- All outputs are registered.
- Host write latency: lut_we_o/lut_waddr_o/lut_wdata_o are valid the cycle after host_wr_en_i is sampled.
- INIT:
  - lut_we_o high for exactly 2^(LUT_AW+1) consecutive cycles (256 at defaults), starting with the first clock edge after nRST deasserts.
  - init_done_o and host_ready_o rise the cycle after the last write.
- FILL:
  - host_ready_o falls the cycle after host_fill_i.
  - 2^LUT_AW consecutive writes follow (128 at defaults).
  - host_ready_o returns the cycle after the last write.
- Commit:
  - host_ready_o falls the cycle after host_commit_i.
  - rd_bank_o toggles, and commit_done_o is high for one cycle, on the cycle after the qualifying vdata_valid_i is sampled.
  - host_ready_o rises that same cycle.

## Test plan
- Reset release → 256 consecutive writes at addr 0x00..0xFF with data {a[6:0],a[6]} (addr 0x7F → 0xFF, 0xFF → 0xFF). Then init_done_o=1, host_ready_o=1, rd_bank_o=0.
- IDLE, rd_bank_o=0, write addr 0x10 data 0x55 → next cycle lut_we_o=1, lut_waddr_o=0x90, lut_wdata_o=0x55. Writes during INIT/FILL/ARMED produce no lut_we_o.
- Commit, then nVSYNC_i 1→0, then vdata_valid_i 3 cycles later → rd_bank_o 0→1 and commit_done_o pulse one cycle after that valid. No toggle at the valid strobes preceding the edge.
- Commit and fill in the same cycle → FILL runs 128 writes to bank 1 (addr 0x80..0xFF). No bank swap follows.
- nVSYNC_i edge coincident with commit acceptance → no swap until a second falling edge plus a vdata_valid_i.
- Assert nRST during FILL at write 40 → outputs return to reset values. INIT restarts from address 0 and rd_bank_o=0.
